// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder.
//   - enc_op_e    : mnemonic select codes presented on in_op
//   - OP_* / FN_* : primary opcodes and R-type funct codes
//   - enc_state_e : program sequencing states
//   - r_fmt/i_fmt/j_fmt : field packers for the three word formats
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    ENC_SLL  = 5'd0,
    ENC_SRL  = 5'd1,
    ENC_JR   = 5'd2,
    ENC_JALR = 5'd3,
    ENC_ADD  = 5'd4,
    ENC_SUB  = 5'd5,
    ENC_AND  = 5'd6,
    ENC_OR   = 5'd7,
    ENC_NOR  = 5'd8,
    ENC_SLT  = 5'd9,
    ENC_BEQ  = 5'd10,
    ENC_BNE  = 5'd11,
    ENC_ADDI = 5'd12,
    ENC_ANDI = 5'd13,
    ENC_ORI  = 5'd14,
    ENC_LW   = 5'd15,
    ENC_SW   = 5'd16,
    ENC_J    = 5'd17,
    ENC_JAL  = 5'd18
  } enc_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // FIFO entry is {last, word}
  localparam int unsigned FIFO_W = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } enc_state_e;

  function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] opcode, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm16);
    return {opcode, rs, rt, imm16};
  endfunction

  function automatic logic [31:0] j_fmt(input logic [5:0] opcode, input logic [25:0] addr26);
    return {opcode, addr26};
  endfunction

endpackage

// File: rtl/instr_encoder_fifo2.sv
// Two-entry synchronous FIFO holding encoded words for the memory-write side.
//   clk, reset : clock, synchronous active-high reset (empties FIFO, clears storage)
//   push       : write wr_data (caller guarantees not full)
//   wr_data    : entry to store
//   pop        : drop head entry (caller guarantees not empty)
//   rd_data    : current head entry
//   count      : occupancy 0..2
module instr_encoder_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Packs mnemonic + operand fields into 32-bit MIPS words (R/I/J formats) and
// streams them, each with a byte address, toward instruction memory.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : field tuple handshake
//   in_op               : mnemonic select (enc_op_e)
//   in_last             : tuple ends the program
//   in_rd/rs/rt/shamt   : register and shift fields
//   in_imm16, in_addr26 : immediate / jump target
//   out_valid/out_ready : word handshake toward memory
//   out_word, out_addr  : encoded word and its byte address
//   done                : one-cycle pulse after the last word of a program is consumed
//   err                 : one-cycle pulse after an unsupported in_op is consumed
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic              in_last,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_addr26,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err
);

  enc_state_e        state;
  logic              enc_ok;
  logic [31:0]       enc_word;
  logic              accept;
  logic              push;
  logic              pop;
  logic              head_last;
  logic              last_dropped;
  logic [1:0]        count;
  logic [FIFO_W-1:0] head;

  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    case (in_op)
      ENC_SLL:  enc_word = r_fmt(5'd0, in_rt, in_rd, in_shamt, FN_SLL);
      ENC_SRL:  enc_word = r_fmt(5'd0, in_rt, in_rd, in_shamt, FN_SRL);
      ENC_JR:   enc_word = r_fmt(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      ENC_JALR: enc_word = r_fmt(in_rs, 5'd0, in_rd, 5'd0, FN_JALR);
      ENC_ADD:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
      ENC_SUB:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
      ENC_AND:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, FN_AND);
      ENC_OR:   enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, FN_OR);
      ENC_NOR:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, FN_NOR);
      ENC_SLT:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
      ENC_BEQ:  enc_word = i_fmt(OP_BEQ, in_rs, in_rt, in_imm16);
      ENC_BNE:  enc_word = i_fmt(OP_BNE, in_rs, in_rt, in_imm16);
      ENC_ADDI: enc_word = i_fmt(OP_ADDI, in_rs, in_rt, in_imm16);
      ENC_ANDI: enc_word = i_fmt(OP_ANDI, in_rs, in_rt, in_imm16);
      ENC_ORI:  enc_word = i_fmt(OP_ORI, in_rs, in_rt, in_imm16);
      ENC_LW:   enc_word = i_fmt(OP_LW, in_rs, in_rt, in_imm16);
      ENC_SW:   enc_word = i_fmt(OP_SW, in_rs, in_rt, in_imm16);
      ENC_J:    enc_word = j_fmt(OP_J, in_addr26);
      ENC_JAL:  enc_word = j_fmt(OP_JAL, in_addr26);
      default:  enc_ok   = 1'b0;
    endcase
  end

  // Unsupported tuples still complete the handshake; only supported ones enter the FIFO.
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_ok;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (count != 2'd2) && (state != ST_DRAIN);
  assign out_valid = (count != 2'd0);
  assign out_word  = head[31:0];
  assign head_last = head[32];

  instr_encoder_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({in_last, enc_word}),
    .pop     (pop),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      out_addr     <= BASE_ADDR;
      done         <= 1'b0;
      err          <= 1'b0;
      last_dropped <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= accept & ~enc_ok;
      if (pop) begin
        out_addr <= head_last ? BASE_ADDR : out_addr + ADDR_W'(4);
      end
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            state        <= in_last ? ST_DRAIN : ST_LOAD;
            last_dropped <= in_last & ~enc_ok;
          end
        end
        ST_DRAIN: begin
          // A rejected last tuple leaves no tagged entry behind, so the program
          // ends once the remaining words have drained instead.
          if (pop && head_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (last_dropped && (count == 2'd0)) begin
            state        <= ST_IDLE;
            done         <= 1'b1;
            last_dropped <= 1'b0;
            out_addr     <= BASE_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed program vectors followed by
// randomized tuples, checked against a table-driven reference encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic        in_last;
  logic [4:0]  in_rd, in_rs, in_rt, in_shamt;
  logic [15:0] in_imm16;
  logic [25:0] in_addr26;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        done;
  logic        err;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_last(in_last), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_shamt(in_shamt), .in_imm16(in_imm16), .in_addr26(in_addr26),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int          err_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  bit          draining = 0;
  bit          drop_wait = 0;
  int          drop_from = 0;
  int          done_due = -1;
  logic [31:0] next_addr = BASE;
  bit          rdy_force = 1;
  bit          rdy_val = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference encoder: per-mnemonic format, code and which fields survive.
  function automatic bit ref_enc(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] sh,
                                 input logic [15:0] imm, input logic [25:0] a26,
                                 output logic [31:0] w);
    int kind = 0;
    longint unsigned code = 0;
    longint unsigned f;
    bit k_rs = 1, k_rt = 1, k_rd = 1, k_sh = 0;
    w = '0;
    case (op)
      ENC_SLL:  begin code = 'h00; k_rs = 0; k_sh = 1; end
      ENC_SRL:  begin code = 'h02; k_rs = 0; k_sh = 1; end
      ENC_JR:   begin code = 'h08; k_rt = 0; k_rd = 0; end
      ENC_JALR: begin code = 'h09; k_rt = 0; end
      ENC_ADD:  code = 'h20;
      ENC_SUB:  code = 'h22;
      ENC_AND:  code = 'h24;
      ENC_OR:   code = 'h25;
      ENC_NOR:  code = 'h27;
      ENC_SLT:  code = 'h2A;
      ENC_BEQ:  begin kind = 1; code = 'h04; end
      ENC_BNE:  begin kind = 1; code = 'h05; end
      ENC_ADDI: begin kind = 1; code = 'h08; end
      ENC_ANDI: begin kind = 1; code = 'h0C; end
      ENC_ORI:  begin kind = 1; code = 'h0D; end
      ENC_LW:   begin kind = 1; code = 'h23; end
      ENC_SW:   begin kind = 1; code = 'h2B; end
      ENC_J:    begin kind = 2; code = 'h02; end
      ENC_JAL:  begin kind = 2; code = 'h03; end
      default:  return 1'b0;
    endcase
    if (kind == 0)
      f = (k_rs ? longint'(rs) : 0) * 2097152 + (k_rt ? longint'(rt) : 0) * 65536
        + (k_rd ? longint'(rd) : 0) * 2048 + (k_sh ? longint'(sh) : 0) * 64 + code;
    else if (kind == 1)
      f = code * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    else
      f = code * 67108864 + longint'(a26);
    w = f[31:0];
    return 1'b1;
  endfunction

  // Drive one tuple, wait (bounded) for acceptance, then record expectations.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] a26, input bit last, input bit use_exp,
                      input logic [31:0] exp_w);
    bit          ok;
    logic [31:0] w;
    int          waited = 0;
    exp_t        e;
    in_valid = 1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_shamt = sh;
    in_imm16 = imm; in_addr26 = a26; in_last = last;
    forever begin
      @(negedge clk); #1;
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        in_valid = 0;
        return;
      end
    end
    ok = ref_enc(op, rd, rs, rt, sh, imm, a26, w);
    if (use_exp) w = exp_w;
    if (ok) begin
      e.word = w; e.addr = next_addr; e.last = last;
      sb.push_back(e);
      next_addr = last ? BASE : next_addr + 32'd4;
    end else begin
      err_q.push_back(cyc + 1);
      if (last) begin
        drop_wait = 1; drop_from = cyc + 1; next_addr = BASE;
      end
    end
    if (last) draining = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; in_valid = 0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_in_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    sb.delete(); err_q.delete();
    draining = 0; drop_wait = 0; done_due = -1; next_addr = BASE;
    reset = 0;
  endtask

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_force ? rdy_val : ($urandom_range(9) < 7);
    end
  end

  // Monitor: compares everything the DUT presents each cycle against the scoreboard.
  initial begin
    bit          hold_prev = 0;
    logic [31:0] prev_word = '0, prev_addr = '0;
    bit          exp_err, exp_done;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin hold_prev = 0; continue; end
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      exp_done = (done_due == cyc);
      if (exp_done) draining = 0;
      check("err", err, exp_err);
      check("done", done, exp_done);
      check("in_ready", in_ready, !draining && (sb.size() < 2));
      check("out_valid", out_valid, sb.size() > 0);
      if (hold_prev) begin
        check("hold_word", out_word, prev_word);
        check("hold_addr", out_addr, prev_addr);
      end
      if (drop_wait && sb.size() == 0 && cyc >= drop_from) begin
        drop_wait = 0;
        done_due = cyc + 1;
      end
      if (out_valid && sb.size() > 0) begin
        check("out_word", out_word, sb[0].word);
        check("out_addr", out_addr, sb[0].addr);
        if (out_ready) begin
          e = sb.pop_front();
          if (e.last) done_due = cyc + 1;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_word = out_word;
      prev_addr = out_addr;
    end
  end

  initial begin
    int n;
    reset = 1; in_valid = 0; in_op = '0; in_last = 0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_shamt = '0; in_imm16 = '0; in_addr26 = '0;
    do_reset();

    // Program 1: addi, sll, slt (address wraps past 2^32), bne last.
    send(ENC_ADDI, 5'd0, 5'd0, 5'd16, 5'd0, 16'hFEFE, 26'd0, 0, 1, 32'h2010FEFE);
    send(ENC_SLL, 5'd16, 5'd5, 5'd16, 5'd16, 16'h0, 26'd0, 0, 1, 32'h00108400);
    send(ENC_SLT, 5'd9, 5'd8, 5'd17, 5'd3, 16'h0, 26'd0, 0, 1, 32'h0111482A);
    send(ENC_BNE, 5'd0, 5'd9, 5'd0, 5'd0, 16'hFFFD, 26'd0, 1, 1, 32'h1520FFFD);

    // Program 2 starts at BASE; unsupported op in the middle.
    send(ENC_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 0, 1, 32'h08100000);
    send(5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0, 0, 0, 32'h0);

    // Backpressure: two fill the FIFO, the third waits for the first pop.
    rdy_val = 0;
    send(ENC_JR, 5'd7, 5'd31, 5'd6, 5'd5, 16'h0, 26'd0, 0, 1, 32'h03E00008);
    send(ENC_JALR, 5'd31, 5'd4, 5'd6, 5'd5, 16'h0, 26'd0, 0, 1, 32'h0080F809);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    fork
      send(ENC_LW, 5'd0, 5'd29, 5'd8, 5'd0, 16'h0010, 26'd0, 0, 1, 32'h8FA80010);
      begin repeat (4) @(posedge clk); #1; rdy_val = 1; end
    join

    // Program ends on an unsupported last tuple.
    send(ENC_SUB, 5'd3, 5'd1, 5'd2, 5'd9, 16'h0, 26'd0, 0, 1, 32'h00221822);
    send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 1, 0, 32'h0);

    // Reset with two words queued.
    rdy_val = 0;
    send(ENC_ORI, 5'd0, 5'd1, 5'd2, 5'd0, 16'hABCD, 26'd0, 0, 0, 32'h0);
    send(ENC_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 0, 0, 32'h0);
    do_reset();

    // Randomized tuples with random backpressure.
    rdy_force = 0;
    for (int i = 0; i < 300; i++) begin
      send(5'($urandom_range(22)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), ($urandom_range(7) == 0), 0, 32'h0);
    end
    send(ENC_ADD, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'd0, 1, 0, 32'h0);

    rdy_force = 1; rdy_val = 1;
    n = 0;
    while ((sb.size() != 0 || draining || drop_wait) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      $display("FAIL drain_timeout: %0d words still queued, expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
